// File: rtl/c_xbar_req_ctrl.sv
// Requester side of a wavefront switch allocator: builds the request matrix from
// per-input packet streams and holds granted outputs from head to tail.
module c_xbar_req_ctrl #(
    parameter int unsigned num_ports = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           active,
    input  logic [num_ports-1:0]           in_valid,
    input  logic [num_ports-1:0]           in_head,
    input  logic [num_ports-1:0]           in_tail,
    input  logic [num_ports*num_ports-1:0] in_dest,
    output logic [num_ports-1:0]           in_ready,
    output logic [num_ports*num_ports-1:0] req,
    input  logic [num_ports*num_ports-1:0] gnt,
    output logic                           update,
    output logic [num_ports*num_ports-1:0] xbar_sel,
    output logic [num_ports-1:0]           out_valid
);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e                           state_q [num_ports];
    state_e                           state_d [num_ports];
    logic [num_ports*num_ports-1:0]   conn_q, conn_d;
    logic [num_ports-1:0]             busy_q, busy_d;
    logic [num_ports*num_ports-1:0]   gnt_m;

    // Reset gates req directly so every derived output drops without a clock edge.
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < num_ports; i++) begin
            for (int unsigned o = 0; o < num_ports; o++) begin
                req[i*num_ports+o] = !reset && (state_q[i] == StIdle) && in_valid[i] &&
                                     in_head[i] && in_dest[i*num_ports+o] && !busy_q[o];
            end
        end
    end

    // Stray grant bits outside req are discarded here.
    assign gnt_m    = gnt & req;
    assign update   = |gnt_m;
    assign xbar_sel = conn_q | gnt_m;

    always_comb begin
        out_valid = '0;
        for (int unsigned o = 0; o < num_ports; o++) begin
            for (int unsigned i = 0; i < num_ports; i++) begin
                out_valid[o] = out_valid[o] | (xbar_sel[i*num_ports+o] & in_valid[i]);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        conn_d   = conn_q;
        in_ready = '0;
        for (int unsigned i = 0; i < num_ports; i++) begin
            unique case (state_q[i])
                StIdle: begin
                    if (|gnt_m[i*num_ports +: num_ports]) begin
                        in_ready[i] = 1'b1;
                        // Single-flit packets never take a lock.
                        if (!in_tail[i]) begin
                            state_d[i]                     = StXfer;
                            conn_d[i*num_ports +: num_ports] = gnt_m[i*num_ports +: num_ports];
                        end
                    end
                end
                StXfer: begin
                    in_ready[i] = in_valid[i];
                    if (in_valid[i] && in_tail[i]) begin
                        state_d[i]                     = StIdle;
                        conn_d[i*num_ports +: num_ports] = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy_d = '0;
        for (int unsigned o = 0; o < num_ports; o++) begin
            for (int unsigned i = 0; i < num_ports; i++) begin
                busy_d[o] = busy_d[o] | conn_d[i*num_ports+o];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '{default: StIdle};
            conn_q  <= '0;
            busy_q  <= '0;
        end else if (active) begin
            state_q <= state_d;
            conn_q  <= conn_d;
            busy_q  <= busy_d;
        end
    end

    logic [num_ports-1:0] xfer_head;
    always_comb begin
        xfer_head = '0;
        for (int unsigned i = 0; i < num_ports; i++) begin
            xfer_head[i] = (state_q[i] == StXfer) && in_valid[i] && in_head[i];
        end
    end

    a_no_head_in_xfer: assert property (@(posedge clk) disable iff (reset)
        active |-> (xfer_head == '0));

    a_gnt_within_req: assert property (@(posedge clk) disable iff (reset)
        (gnt & ~req) == '0);

endmodule

// File: tb/tb_c_xbar_req_ctrl.sv
// Directed bench for c_xbar_req_ctrl with P=4; expected outputs are queued per step
// and popped at the following falling edge.
module tb_c_xbar_req_ctrl;

    localparam int unsigned P = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            active = 1'b1;
    logic [P-1:0]    in_valid = '0;
    logic [P-1:0]    in_head = '0;
    logic [P-1:0]    in_tail = '0;
    logic [P*P-1:0]  in_dest = '0;
    logic [P-1:0]    in_ready;
    logic [P*P-1:0]  req;
    logic [P*P-1:0]  gnt = '0;
    logic            update;
    logic [P*P-1:0]  xbar_sel;
    logic [P-1:0]    out_valid;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string        tag;
        logic [P-1:0] rdy;
        logic [15:0]  req;
        logic [15:0]  sel;
        logic [P-1:0] ov;
        logic         upd;
    } exp_t;

    exp_t exp_q[$];

    c_xbar_req_ctrl #(.num_ports(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .active    (active),
        .in_valid  (in_valid),
        .in_head   (in_head),
        .in_tail   (in_tail),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .req       (req),
        .gnt       (gnt),
        .update    (update),
        .xbar_sel  (xbar_sel),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Bit position of (input i, output o) in any P*P matrix.
    function automatic logic [15:0] m(input int i, input int o);
        logic [15:0] one;
        one = 16'd1;
        return one << (i * P + o);
    endfunction

    task automatic step(input string tag, input logic rst, input logic act,
                        input logic [P-1:0] v, input logic [P-1:0] h, input logic [P-1:0] t,
                        input logic [15:0] dst, input logic [15:0] g,
                        input logic [P-1:0] e_rdy, input logic [15:0] e_req,
                        input logic [15:0] e_sel, input logic [P-1:0] e_ov, input logic e_upd);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        active   = act;
        in_valid = v;
        in_head  = h;
        in_tail  = t;
        in_dest  = dst;
        gnt      = g;
        exp_q.push_back('{tag, e_rdy, e_req, e_sel, e_ov, e_upd});
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        assert (in_ready === e.rdy) else begin
            miscompares++;
            $error("FAIL %s in_ready got %h want %h", e.tag, in_ready, e.rdy);
        end
        vectors++;
        assert (req === e.req) else begin
            miscompares++;
            $error("FAIL %s req got %h want %h", e.tag, req, e.req);
        end
        vectors++;
        assert (xbar_sel === e.sel) else begin
            miscompares++;
            $error("FAIL %s xbar_sel got %h want %h", e.tag, xbar_sel, e.sel);
        end
        vectors++;
        assert (out_valid === e.ov) else begin
            miscompares++;
            $error("FAIL %s out_valid got %h want %h", e.tag, out_valid, e.ov);
        end
        vectors++;
        assert (update === e.upd) else begin
            miscompares++;
            $error("FAIL %s update got %h want %h", e.tag, update, e.upd);
        end
    endtask

    initial begin
        // tag, rst, act, valid, head, tail, dest, gnt, rdy, req, sel, ov, upd
        step("reset_outs", 1, 1, 4'hF, 4'hF, 4'h0, m(0,0)|m(1,1)|m(2,2)|m(3,3), 16'h0,
             4'h0, 16'h0, 16'h0, 4'h0, 1'b0);
        step("single", 0, 1, 4'h1, 4'h1, 4'h1, m(0,2), m(0,2),
             4'h1, m(0,2), m(0,2), 4'b0100, 1'b1);
        step("single_nolock", 0, 1, 4'h2, 4'h2, 4'h2, m(1,2), 16'h0,
             4'h0, m(1,2), 16'h0, 4'h0, 1'b0);
        step("pk1_head", 0, 1, 4'h2, 4'h2, 4'h0, m(1,0), m(1,0),
             4'h2, m(1,0), m(1,0), 4'b0001, 1'b1);
        step("pk1_body", 0, 1, 4'h6, 4'h4, 4'h0, m(2,0), 16'h0,
             4'h2, 16'h0, m(1,0), 4'b0001, 1'b0);
        step("pk1_tail", 0, 1, 4'h6, 4'h4, 4'h2, m(2,0), 16'h0,
             4'h2, 16'h0, m(1,0), 4'b0001, 1'b0);
        step("pk1_released", 0, 1, 4'h4, 4'h4, 4'h0, m(2,0), 16'h0,
             4'h0, m(2,0), 16'h0, 4'h0, 1'b0);
        step("in2_head", 0, 1, 4'h4, 4'h4, 4'h0, m(2,0), m(2,0),
             4'h4, m(2,0), m(2,0), 4'b0001, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step("in2_stall", 0, 1, 4'h1, 4'h1, 4'h0, m(0,0), 16'h0,
                 4'h0, 16'h0, m(2,0), 4'h0, 1'b0);
        end
        step("in2_frozen", 0, 0, 4'h5, 4'h1, 4'h4, m(0,0), 16'h0,
             4'h4, 16'h0, m(2,0), 4'b0001, 1'b0);
        step("in2_resume", 0, 1, 4'h5, 4'h1, 4'h0, m(0,0), 16'h0,
             4'h4, 16'h0, m(2,0), 4'b0001, 1'b0);
        step("contend", 0, 1, 4'hD, 4'h9, 4'h0, m(0,1)|m(3,1), m(3,1),
             4'hC, m(0,1)|m(3,1), m(2,0)|m(3,1), 4'b0011, 1'b1);
        step("in3_body", 0, 1, 4'hD, 4'h1, 4'h4, m(0,1), 16'h0,
             4'hC, 16'h0, m(2,0)|m(3,1), 4'b0011, 1'b0);
        step("in3_tail", 0, 1, 4'h9, 4'h1, 4'h8, m(0,1), 16'h0,
             4'h8, 16'h0, m(3,1), 4'b0010, 1'b0);
        step("in0_rereq", 0, 1, 4'h1, 4'h1, 4'h0, m(0,1), 16'h0,
             4'h0, m(0,1), 16'h0, 4'h0, 1'b0);
        step("in0_head", 0, 1, 4'h1, 4'h1, 4'h0, m(0,1), m(0,1),
             4'h1, m(0,1), m(0,1), 4'b0010, 1'b1);
        step("in0_body", 0, 1, 4'h1, 4'h0, 4'h0, 16'h0, 16'h0,
             4'h1, 16'h0, m(0,1), 4'b0010, 1'b0);
        step("reset_mid", 1, 1, 4'h3, 4'h2, 4'h0, m(1,1), 16'h0,
             4'h0, 16'h0, 16'h0, 4'h0, 1'b0);
        step("post_reset", 0, 1, 4'h3, 4'h3, 4'h0, m(0,2)|m(1,1), 16'h0,
             4'h0, m(0,2)|m(1,1), 16'h0, 4'h0, 1'b0);

        if (exp_q.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_drain got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
